// File: rtl/addition_stage4.sv
// Iterative post-add normalizer: renormalizes a carry, left-shifts one bit per
// cycle to restore the hidden bit, and classifies zero/overflow/underflow results.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// NORM  | one normalization step per cycle
// DONE  | result presented, held until out_ready
module addition_stage4 #(
  parameter int MENT_WIDTH = 23,
  parameter int EXP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MENT_WIDTH+1:0] sum_in,
  input  logic [EXP_WIDTH-1:0]  exp_in,
  input  logic                  sign_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [EXP_WIDTH-1:0]  out_exp,
  output logic [MENT_WIDTH-1:0] out_frac,
  output logic                  out_zero,
  output logic                  out_overflow,
  output logic                  out_underflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NORM = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [EXP_WIDTH-1:0] EXP_ONE = {{(EXP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [EXP_WIDTH-1:0] EXP_ALL = '1;

  logic [1:0]            state;
  logic [MENT_WIDTH+1:0] mant;
  logic [EXP_WIDTH-1:0]  expo;
  logic                  sgn;

  logic [EXP_WIDTH-1:0]  exp_inc;
  logic                  norm_done;
  logic [EXP_WIDTH-1:0]  r_exp;
  logic [MENT_WIDTH-1:0] r_frac;
  logic                  r_zero;
  logic                  r_ovf;
  logic                  r_unf;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign exp_inc   = expo + EXP_ONE;

  // Priority-ordered classification of the current M/E pair; norm_done low means shift again.
  always_comb begin
    norm_done = 1'b1;
    r_exp     = '0;
    r_frac    = '0;
    r_zero    = 1'b0;
    r_ovf     = 1'b0;
    r_unf     = 1'b0;
    if (&expo) begin
      r_exp = EXP_ALL;
      r_ovf = 1'b1;
    end else if (mant == '0) begin
      r_zero = 1'b1;
    end else if (mant[MENT_WIDTH+1]) begin
      if (&exp_inc) begin
        r_exp = EXP_ALL;
        r_ovf = 1'b1;
      end else begin
        r_exp  = exp_inc;
        r_frac = mant[MENT_WIDTH:1];
      end
    end else if (mant[MENT_WIDTH]) begin
      r_exp  = expo;
      r_frac = mant[MENT_WIDTH-1:0];
    end else if (expo <= EXP_ONE) begin
      r_unf  = 1'b1;
      r_frac = mant[MENT_WIDTH-1:0];
    end else begin
      norm_done = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      mant          <= '0;
      expo          <= '0;
      sgn           <= 1'b0;
      out_sign      <= 1'b0;
      out_exp       <= '0;
      out_frac      <= '0;
      out_zero      <= 1'b0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mant  <= sum_in;
            expo  <= exp_in;
            sgn   <= sign_in;
            state <= NORM;
          end
        end
        NORM: begin
          if (norm_done) begin
            out_sign      <= sgn;
            out_exp       <= r_exp;
            out_frac      <= r_frac;
            out_zero      <= r_zero;
            out_overflow  <= r_ovf;
            out_underflow <= r_unf;
            state         <= DONE;
          end else begin
            mant <= mant << 1;
            expo <= expo - EXP_ONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
